// File: rtl/seg_pkg.sv
// Shared constants and FSM encoding for the multiplexed 4-digit decimal display.
package seg_pkg;

  localparam logic [4:0] BLANK_CODE = 5'h1F;
  localparam int         NUM_DIGITS = 4;
  localparam int         MAX_VALUE  = 9999;
  localparam int         VALUE_W    = 14;
  localparam int         BCD_W      = 4 * NUM_DIGITS;
  localparam int         DD_ITERS   = VALUE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } scan_state_e;

  function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
    return (v > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : v;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble: one add-3/shift iteration per cycle after start_i.
// done_o flags the cycle in which the final iteration is applied.
module bin2bcd_dd
  import seg_pkg::*;
(
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int SR_W  = BCD_W + VALUE_W;
  localparam int CNT_W = $clog2(DD_ITERS);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [BCD_W-1:0] adj;
  logic             last_iter;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib            = sr_q[VALUE_W + 4*gi +: 4];
      assign adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign last_iter = run_q && (cnt_q == CNT_W'(DD_ITERS - 1));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      sr_d  = {{BCD_W{1'b0}}, bin_i};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sr_d  = {adj, sr_q[VALUE_W-1:0]} << 1;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = last_iter;
  assign bcd_o  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_digit_scan.sv
// Binary-to-decimal 4-digit display driver: captures a value, converts it to
// blanked BCD codes, and time-multiplexes them onto active-low anodes.
module seg_digit_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clkIn,
  input  logic               rstIn,
  input  logic [VALUE_W-1:0] valueIn,
  input  logic               loadIn,
  output logic               busyOut,
  output logic               overflowOut,
  output logic [4:0]         digitOut,
  output logic [3:0]         anodeOut
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_e      state_q, state_d;
  logic             accept, commit;
  logic             dd_done;
  logic [BCD_W-1:0] dd_bcd;
  logic             ovf_q;
  logic [4:0]       code_d   [NUM_DIGITS];
  logic [4:0]       stored_q [NUM_DIGITS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;
  logic [3:0]       anode_q;
  logic [4:0]       digit_q;

  always_ff @(posedge clkIn) begin
    if (rstIn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CONVERT;
      ST_CONVERT: if (dd_done) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busyOut = (state_q != ST_IDLE);
    accept  = loadIn && (state_q == ST_IDLE);
    commit  = (state_q == ST_COMMIT);
  end

  bin2bcd_dd u_dd (
    .clk_i   (clkIn),
    .srst_i  (rstIn),
    .start_i (accept),
    .bin_i   (clamp_value(valueIn)),
    .done_o  (dd_done),
    .bcd_o   (dd_bcd)
  );

  always_ff @(posedge clkIn) begin
    if (rstIn)       ovf_q <= 1'b0;
    else if (accept) ovf_q <= (valueIn > VALUE_W'(MAX_VALUE));
  end
  assign overflowOut = ovf_q;

  // Leading-zero blanking: a digit shows only if it or a higher digit is nonzero.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib       = dd_bcd[4*i +: 4];
      seen      = seen | (nib != 4'd0) | (i == 0);
      code_d[i] = seen ? {1'b0, nib} : BLANK_CODE;
    end
  end

  always_ff @(posedge clkIn) begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rstIn)       stored_q[i] <= BLANK_CODE;
      else if (commit) stored_q[i] <= code_d[i];
    end
  end

  assign tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  // stored_q is read before a same-edge commit lands, so a coinciding tick shows the old digit.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      cnt_q   <= '0;
      idx_q   <= IDX_W'(NUM_DIGITS - 1);
      anode_q <= 4'hF;
      digit_q <= BLANK_CODE;
    end else begin
      cnt_q <= cnt_d;
      if (tick) begin
        idx_q   <= idx_d;
        anode_q <= ~(4'b0001 << idx_d);
        digit_q <= stored_q[idx_d];
      end
    end
  end

  assign anodeOut = anode_q;
  assign digitOut = digit_q;

endmodule

// File: tb/tb_seg_digit_scan.sv
// Directed bench for seg_digit_scan with REFRESH_DIV=4; outputs sampled on falling edges.
module tb_seg_digit_scan;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic [13:0] valueIn;
  logic        loadIn;
  logic        busyOut;
  logic        overflowOut;
  logic [4:0]  digitOut;
  logic [3:0]  anodeOut;

  int checks   = 0;
  int failures = 0;

  seg_digit_scan #(.REFRESH_DIV(4)) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .valueIn     (valueIn),
    .loadIn      (loadIn),
    .busyOut     (busyOut),
    .overflowOut (overflowOut),
    .digitOut    (digitOut),
    .anodeOut    (anodeOut)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sync to the next entry into slot 0, then verify the four slots in order.
  task automatic check_display(input string tag, input logic [4:0] e0, input logic [4:0] e1,
                               input logic [4:0] e2, input logic [4:0] e3);
    logic [3:0] prev;
    bit         found;
    logic [4:0] exp_d [4];
    logic [3:0] exp_a [4];
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    exp_a[0] = 4'hE; exp_a[1] = 4'hD; exp_a[2] = 4'hB; exp_a[3] = 4'h7;
    repeat (5) @(negedge clkIn);
    found = 1'b0;
    prev  = anodeOut;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clkIn);
      if (prev != 4'hE && anodeOut == 4'hE) found = 1'b1;
      prev = anodeOut;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (4) @(negedge clkIn);
      chk($sformatf("%s_anode%0d", tag, k), 32'(anodeOut), 32'(exp_a[k]));
      chk($sformatf("%s_digit%0d", tag, k), 32'(digitOut), 32'(exp_d[k]));
    end
    $display("display %s: %h %h %h %h", tag, e0, e1, e2, e3);
  endtask

  // inject: 0 none, 1 extra load at N+5, 2 extra load in the COMMIT cycle (N+15)
  task automatic do_load(input string tag, input logic [13:0] v, input logic ovf, input int inject);
    int busy_cycles;
    @(negedge clkIn);
    valueIn = v;
    loadIn  = 1'b1;
    @(negedge clkIn);
    loadIn  = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busyOut), 32'd1);
    chk({tag, "_ovf"}, 32'(overflowOut), 32'(ovf));
    busy_cycles = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clkIn);
      if ((inject == 1 && i == 4) || (inject == 2 && i == 14)) begin
        valueIn = (inject == 1) ? 14'd5678 : 14'd3333;
        loadIn  = 1'b1;
      end
      if ((inject == 1 && i == 5) || (inject == 2 && i == 15)) loadIn = 1'b0;
      if (!busyOut) break;
      busy_cycles++;
    end
    loadIn = 1'b0;
    chk({tag, "_busy_len"}, 32'(busy_cycles), 32'd15);
    if (inject == 2) begin
      repeat (2) begin
        @(negedge clkIn);
        chk({tag, "_commit_load_ignored"}, 32'(busyOut), 32'd0);
      end
    end
    chk({tag, "_ovf_hold"}, 32'(overflowOut), 32'(ovf));
    $display("load %s value=%0d busy_cycles=%0d ovf=%0b", tag, v, busy_cycles, overflowOut);
  endtask

  initial begin
    logic [3:0] prev;
    bit         found;
    logic [3:0] scan_seq [4];
    scan_seq[0] = 4'hE; scan_seq[1] = 4'hD; scan_seq[2] = 4'hB; scan_seq[3] = 4'h7;

    rstIn   = 1'b1;
    loadIn  = 1'b0;
    valueIn = '0;
    repeat (3) @(negedge clkIn);
    chk("rst_anode", 32'(anodeOut), 32'hF);
    chk("rst_digit", 32'(digitOut), 32'h1F);
    chk("rst_busy",  32'(busyOut), 32'd0);
    chk("rst_ovf",   32'(overflowOut), 32'd0);
    rstIn = 1'b0;

    // Idle scan after reset: F for 3 cycles, then E,D,B,7,E every 4 cycles.
    for (int e = 1; e <= 20; e++) begin
      @(negedge clkIn);
      chk($sformatf("idle_anode_c%0d", e), 32'(anodeOut),
          (e < 4) ? 32'hF : 32'(scan_seq[((e / 4) - 1) % 4]));
      chk($sformatf("idle_digit_c%0d", e), 32'(digitOut), 32'h1F);
    end
    $display("idle scan done");

    do_load("v1234", 14'd1234, 1'b0, 1);
    check_display("v1234", 5'd4, 5'd3, 5'd2, 5'd1);

    // Commit landing on a slot-0 tick: load one cycle after the tick edge.
    found = 1'b0;
    prev  = anodeOut;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clkIn);
      if (prev != 4'hE && anodeOut == 4'hE) found = 1'b1;
      prev = anodeOut;
    end
    chk("tickcommit_sync", 32'(found), 32'd1);
    valueIn = 14'd5678;
    loadIn  = 1'b1;
    @(negedge clkIn);
    loadIn = 1'b0;
    repeat (15) @(negedge clkIn);
    chk("tickcommit_anode0", 32'(anodeOut), 32'hE);
    chk("tickcommit_old_digit0", 32'(digitOut), 32'd4);
    repeat (4) @(negedge clkIn);
    chk("tickcommit_anode1", 32'(anodeOut), 32'hD);
    chk("tickcommit_new_digit1", 32'(digitOut), 32'd7);
    repeat (12) @(negedge clkIn);
    chk("tickcommit_anode0_next", 32'(anodeOut), 32'hE);
    chk("tickcommit_new_digit0", 32'(digitOut), 32'd8);
    $display("tick-coincident commit checked");

    do_load("v7", 14'd7, 1'b0, 0);
    check_display("v7", 5'd7, 5'h1F, 5'h1F, 5'h1F);
    do_load("v0", 14'd0, 1'b0, 0);
    check_display("v0", 5'd0, 5'h1F, 5'h1F, 5'h1F);
    do_load("v1005", 14'd1005, 1'b0, 2);
    check_display("v1005", 5'd5, 5'd0, 5'd0, 5'd1);
    do_load("v12000", 14'd12000, 1'b1, 0);
    check_display("v12000", 5'd9, 5'd9, 5'd9, 5'd9);
    do_load("v42", 14'd42, 1'b0, 0);
    check_display("v42", 5'd2, 5'd4, 5'h1F, 5'h1F);

    // Reset in cycle N+8 of a conversion: abort, nothing committed afterwards.
    @(negedge clkIn);
    valueIn = 14'd9876;
    loadIn  = 1'b1;
    @(negedge clkIn);
    loadIn = 1'b0;
    chk("abort_busy", 32'(busyOut), 32'd1);
    repeat (7) @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    chk("abort_rst_anode", 32'(anodeOut), 32'hF);
    chk("abort_rst_digit", 32'(digitOut), 32'h1F);
    chk("abort_rst_busy",  32'(busyOut), 32'd0);
    chk("abort_rst_ovf",   32'(overflowOut), 32'd0);
    @(negedge clkIn);
    rstIn = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clkIn);
      chk($sformatf("abort_busy_c%0d", c), 32'(busyOut), 32'd0);
      chk($sformatf("abort_digit_c%0d", c), 32'(digitOut), 32'h1F);
    end
    chk("abort_first_tick_anode", 32'(anodeOut), 32'(scan_seq[(24 / 4 - 1) % 4]));
    $display("reset abort checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_digit_scan.md
SEG_DIGIT_SCAN -- requirements
Module: seg_digit_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit stays selected (minimum 2).
REQ-002 The block SHALL have port clkIn  input  1  the single clock; all logic is rising-edge clkIn.
REQ-003 The block SHALL have port rstIn  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port valueIn  input  14  unsigned binary value to display.
REQ-005 The block SHALL have port loadIn  input  1  single-cycle request to capture valueIn.
REQ-006 The block SHALL have port busyOut  output  1  high while a conversion is in progress.
REQ-007 The block SHALL have port overflowOut  output  1  high when the last accepted valueIn exceeded 9999.
REQ-008 The block SHALL have port digitOut  output  5  digit code for the downstream segment decoder: 0-9 decimal digit, 5'h1F blank.
REQ-009 The block SHALL have port anodeOut  output  4  active-low one-hot digit select; bit 0 is the least significant digit.

Function
REQ-010 The block SHALL accept loadIn only when busyOut is low; loadIn while busyOut is high SHALL be ignored with no side effect.
REQ-011 On acceptance in cycle N, the block SHALL register min(valueIn, 9999), set overflowOut to (valueIn > 9999) in cycle N+1, and hold overflowOut until the next accepted load.
REQ-012 The block SHALL convert the registered value to four BCD digits by 14-iteration double-dabble (add 3 to any nibble >= 5, then shift left), one iteration per cycle.
REQ-013 The FSM SHALL have states IDLE, CONVERT, COMMIT: IDLE->CONVERT on accepted load; CONVERT->COMMIT after the 14th iteration; COMMIT->IDLE after one cycle.
REQ-014 busyOut SHALL be high in cycles N+1 through N+15 inclusive, and the displayed digit registers SHALL update at the clock edge ending cycle N+15 (COMMIT).
REQ-015 A load request in the same cycle busyOut falls (COMMIT->IDLE edge) SHALL NOT be accepted; acceptance requires busyOut low during the request cycle.
REQ-016 At commit, leading-zero blanking SHALL replace every digit above the most significant nonzero digit with 5'h1F; value 0 SHALL show code 0 on digit 0 and blank on digits 1-3.
REQ-017 The scan counter SHALL count 0..REFRESH_DIV-1 and wrap; each wrap is a tick advancing the digit index 3->0->1->2->3.
REQ-018 On each tick, anodeOut SHALL become ~(4'b0001 << index) and digitOut the stored code of the new index, both registered in the same cycle (no anode/digit skew).
REQ-019 Between ticks, anodeOut and digitOut SHALL hold; a commit between ticks SHALL become visible at the next tick, never mid-slot.
REQ-020 A tick coinciding with commit SHALL present the pre-commit digit for that slot.
REQ-021 Scanning SHALL continue unaffected during conversion.

Reset
REQ-022 While rstIn is high at a clock edge: anodeOut=4'hF, digitOut=5'h1F, busyOut=0, overflowOut=0, stored digits all 5'h1F, index=3, scan counter=0, FSM=IDLE.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion; no partial result SHALL be committed.
REQ-024 After reset release, the first tick (REFRESH_DIV cycles later) SHALL select digit 0 with anodeOut=4'hE.

Structure
REQ-025 A shared package seg_pkg SHALL hold BLANK_CODE (5'h1F), NUM_DIGITS (4), MAX_VALUE (9999) and the FSM state encoding.
REQ-026 The double-dabble datapath and its iteration counter SHALL be a sub-module bin2bcd_dd with start/done handshake; scan and blanking logic SHALL stay in seg_digit_scan.

Verification (REFRESH_DIV=4)
REQ-027 Reset then idle 20 cycles -> anodeOut sequence 4'hF, then E,D,B,7,E every 4 cycles; digitOut 5'h1F throughout.
REQ-028 Load 1234 -> busyOut high exactly 15 cycles; subsequent scan shows digits 4,3,2,1 on anodes E,D,B,7.
REQ-029 Load 7 -> digits 7,1F,1F,1F; load 0 -> 0,1F,1F,1F; load 1005 -> 5,0,0,1.
REQ-030 Load 12000 -> overflowOut=1 next cycle, display 9,9,9,9; then load 42 -> overflowOut=0, display 2,4,1F,1F.
REQ-031 Load 1234, pulse loadIn with 5678 at cycle N+5 -> ignored, display 1234; assert rstIn at N+8 -> all outputs at reset values, no commit follows.
REQ-032 Timed commit landing exactly on a tick cycle -> that slot shows old digit; new digit appears from the following tick onward.
